// File: rtl/pipeline_stage_register_if.sv
// Valid/ready bundle for one elastic pipeline register.
// Slave is the register itself, master is the stage pair around it.
interface pipeline_stage_register_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             stall_clr_i;
  logic [CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  flush_i,
    input  valid_i,
    input  data_i,
    input  ready_i,
    input  stall_clr_i,
    output ready_o,
    output valid_o,
    output data_o,
    output stall_cnt_o
  );

  modport master (
    output flush_i,
    output valid_i,
    output data_i,
    output ready_i,
    output stall_clr_i,
    input  ready_o,
    input  valid_o,
    input  data_o,
    input  stall_cnt_o
  );
endinterface

// File: rtl/pipeline_stage_register.sv
// Elastic inter-stage register: two-entry skid buffer, flush
// to bubble, saturating stall counter. Updates on falling clk.
module pipeline_stage_register #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(32'h0000_0013),
  parameter int               CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  pipeline_stage_register_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             valid_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_w;
  logic             out_w;

  assign in_w  = bus.valid_i & ready_q;
  assign out_w = valid_q & bus.ready_i;

  // Next entry state: M always holds the older entry, S the younger.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_w) begin
            state_d = BUSY;
            m_d     = bus.data_i;
          end
        end
        BUSY: begin
          if (in_w && out_w) begin
            m_d = bus.data_i;
          end else if (in_w) begin
            state_d = FULL;
            s_d     = bus.data_i;
          end else if (out_w) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_w) begin
            state_d = BUSY;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Entry registers plus registered valid/ready flags.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      m_q     <= BUBBLE;
      s_q     <= BUBBLE;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // Stall count: clear wins, flush freezes, saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.stall_clr_i) begin
      cnt_d = '0;
    end else if (valid_q && !bus.ready_i && !bus.flush_i
                 && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(negedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.ready_o     = ready_q;
  assign bus.valid_o     = valid_q;
  assign bus.data_o      = valid_q ? m_q : BUBBLE;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: directed cases plus random
// traffic against a queue-based reference model.
module tb_pipeline_stage_register;

  localparam int          TB_CNT_W = 4;
  localparam int          CMAX     = (1 << TB_CNT_W) - 1;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk;
  logic rst;

  pipeline_stage_register_if #(
    .WIDTH(32),
    .CNT_W(TB_CNT_W)
  ) bus ();

  pipeline_stage_register #(
    .WIDTH(32),
    .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] mq[$];
  int          mcnt   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One falling edge: drive inputs, step the model, compare.
  task automatic cyc(input logic v, input logic [31:0] d,
                     input logic r, input logic f,
                     input logic c);
    bit mv;
    bit mr;
    @(posedge clk);
    bus.valid_i     = v;
    bus.data_i      = d;
    bus.ready_i     = r;
    bus.flush_i     = f;
    bus.stall_clr_i = c;
    mv = (mq.size() > 0);
    mr = (mq.size() < 2);
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (c) mcnt = 0;
      else if (mv && !r && !f && mcnt < CMAX) mcnt++;
      if (f) begin
        mq.delete();
      end else begin
        if (mv && r) mq.delete(0);
        if (v && mr) mq.push_back(d);
      end
    end
    @(negedge clk);
    #1;
    chk("valid_o", 32'(bus.valid_o), 32'(mq.size() > 0));
    chk("ready_o", 32'(bus.ready_o), 32'(mq.size() < 2));
    chk("data_o", bus.data_o, (mq.size() > 0) ? mq[0] : NOP);
    chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(mcnt));
  endtask

  initial begin
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.data_i      = '0;
    bus.ready_i     = 1'b0;
    bus.flush_i     = 1'b0;
    bus.stall_clr_i = 1'b0;

    // Reset then idle
    cyc(0, 0, 0, 0, 0);
    cyc(1, 32'hdead, 1, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 1, 0, 0);
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_ready", 32'(bus.ready_o), 1);
    chk("rst_data", bus.data_o, 32'h13);
    chk("rst_cnt", 32'(bus.stall_cnt_o), 0);

    // Back-to-back stream
    cyc(1, 32'h11, 1, 0, 0);
    chk("s11", bus.data_o, 32'h11);
    cyc(1, 32'h22, 1, 0, 0);
    chk("s22", bus.data_o, 32'h22);
    cyc(1, 32'h33, 1, 0, 0);
    chk("s33", bus.data_o, 32'h33);
    chk("s_ready", 32'(bus.ready_o), 1);
    cyc(0, 0, 1, 0, 0);
    chk("s_drain", 32'(bus.valid_o), 0);

    // Stall into FULL, then recover in order
    cyc(1, 32'hA1, 0, 0, 0);
    chk("a1", bus.data_o, 32'hA1);
    cyc(1, 32'hA2, 0, 0, 0);
    chk("full_ready", 32'(bus.ready_o), 0);
    chk("full_data", bus.data_o, 32'hA1);
    chk("full_cnt1", 32'(bus.stall_cnt_o), 1);
    cyc(1, 32'hA2, 0, 0, 0);
    chk("full_cnt2", 32'(bus.stall_cnt_o), 2);
    cyc(0, 0, 1, 0, 0);
    chk("rec_a2", bus.data_o, 32'hA2);
    chk("rec_ready", 32'(bus.ready_o), 1);
    cyc(0, 0, 1, 0, 0);
    chk("rec_empty", 32'(bus.valid_o), 0);
    cyc(0, 0, 1, 0, 1);

    // Flush while FULL drops both entries and the incoming word
    cyc(1, 32'hB1, 0, 0, 0);
    cyc(1, 32'hB2, 0, 0, 0);
    cyc(1, 32'hB3, 0, 1, 0);
    chk("fl_valid", 32'(bus.valid_o), 0);
    chk("fl_data", bus.data_o, 32'h13);
    chk("fl_ready", 32'(bus.ready_o), 1);
    chk("fl_cnt", 32'(bus.stall_cnt_o), 1);
    cyc(0, 0, 1, 0, 0);
    chk("fl_idle", bus.data_o, 32'h13);

    // Saturation at 15, then clear beats a concurrent stall
    cyc(1, 32'hC1, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    chk("sat", 32'(bus.stall_cnt_o), 15);
    cyc(0, 0, 0, 0, 1);
    chk("clr_wins", 32'(bus.stall_cnt_o), 0);
    cyc(0, 0, 1, 0, 0);

    // Reset while FULL
    cyc(1, 32'hD1, 0, 0, 0);
    cyc(1, 32'hD2, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 32'hD3, 1, 1, 0);
    rst = 1'b0;
    chk("rstf_valid", 32'(bus.valid_o), 0);
    chk("rstf_cnt", 32'(bus.stall_cnt_o), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 9) < 7, $urandom,
          $urandom_range(0, 9) < 5,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 3);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_register.md
# pipeline_stage_register

Parametrised elastic pipeline register for the RISC-V core: it replaces the fixed, always-loading inter-stage registers with one generic block carrying a WIDTH-bit payload under a valid/ready handshake. It adds stall back-pressure through a two-entry skid buffer, so `ready_o` comes straight from a register. It also supports flush with bubble insertion and a saturating stall-cycle counter. It sits between any two pipeline stages (fetch/decode, decode/execute, execute/memory, memory/writeback).

## Interface
- `WIDTH`, 32: payload width in bits; matches DATA_BUS for single-word stages, wider for bundled stage payloads.
- `BUBBLE`, 32'h0000_0013 zero-extended to WIDTH: value driven on `data_o` whenever `valid_o` = 0 (NOP, `addi x0,x0,0`).
- `CNT_W`, 16: stall counter width.
- `clk` in 1: stage clock; all state updates on the falling edge, matching the rest of the pipeline.
- `rst` in 1: synchronous, active-high reset, sampled on the falling edge of `clk`.
- `flush_i` in 1: discard all held entries and any input this cycle.
- `valid_i` in 1: upstream payload valid.
- `ready_o` out 1: block can accept; registered.
- `data_i` in WIDTH: upstream payload.
- `valid_o` out 1: output payload valid.
- `ready_i` in 1: downstream accepts.
- `data_o` out WIDTH: output payload.
- `stall_clr_i` in 1: clear the stall counter.
- `stall_cnt_o` out CNT_W: count of cycles with `valid_o`=1 and `ready_i`=0.

## Operation
- Storage:
  - main register M (drives the output);
  - skid register S;
  - state EMPTY / BUSY / FULL.
- Outputs by state:
  - `valid_o` = state≠EMPTY.
  - `ready_o` = state≠FULL.
  - `data_o` = M when `valid_o`, else BUBBLE.
- Handshake:
  - in = `valid_i` & `ready_o`.
  - out = `valid_o` & `ready_i`.
  - Transfers are evaluated at the falling edge.
- Transitions when not reset and not flush:
  - EMPTY: in → BUSY, M←`data_i`; otherwise stay.
  - BUSY, in & out → BUSY, M←`data_i`.
  - BUSY, in & !out → FULL, S←`data_i`.
  - BUSY, !in & out → EMPTY.
  - BUSY, neither → stay, M held.
  - FULL: out → BUSY, M←S; otherwise stay. No input is possible because `ready_o`=0.
- Order is preserved: the S entry is always younger than the M entry.
- Flush:
  - Next state is EMPTY, regardless of current state or handshake.
  - `data_i` presented that cycle is dropped.
  - Contents of M and S are don't-care afterwards, but `data_o` must read BUBBLE.
- Priority: `rst` > `flush_i` > handshake.
- `valid_i` with `ready_o`=0 is not an error. Upstream must hold `data_i`/`valid_i` stable until accepted; the block does not check this.
- Stall counter, in priority order:
  - `rst` or `stall_clr_i` → 0;
  - else `valid_o` & !`ready_i` & !`flush_i` → +1, saturating at 2^CNT_W−1 with no wrap;
  - `flush_i` does not clear the counter.
- Reset values:
  - state EMPTY, so `valid_o`=0, `ready_o`=1;
  - `data_o`=BUBBLE;
  - `stall_cnt_o`=0;
  - M and S cleared to BUBBLE.

## Timing
- Latency: a payload accepted at falling edge n appears on `data_o` with `valid_o`=1 immediately after edge n, one register stage.
- Throughput: one transfer per cycle in BUSY when `ready_i`=1 continuously.
- `ready_o` is a pure register output, with no combinational path from `ready_i`.
- `valid_o`, `data_o` and `stall_cnt_o` are register outputs, except the BUBBLE mux on `data_o`, which decodes from state only.
- Stall recovery: after `ready_i` rises in FULL, `ready_o` returns high after the next falling edge.
- Reset mid-FULL: both entries are lost and EMPTY is entered at that edge. A simultaneous `flush_i` has no additional effect.
- Flush in FULL while `ready_i`=1: the M entry counts as transferred that edge (downstream sampled it); S is dropped.

## Test plan
- Reset, then idle → `valid_o`=0, `ready_o`=1, `data_o`=0x00000013, `stall_cnt_o`=0.
- Stream 0x11, 0x22, 0x33 on consecutive edges with `ready_i`=1 → `data_o` shows 0x11, 0x22, 0x33 one edge later each; state stays BUSY.
- Send 0xA1, drop `ready_i`, send 0xA2:
  - required: `ready_o`=0, state FULL, `data_o` holds 0xA1, `stall_cnt_o` increments each stalled edge;
  - then raise `ready_i`: outputs 0xA1 then 0xA2, in order, with no loss or duplication.
- In FULL (0xB1/0xB2), assert `flush_i` with `valid_i`=1 carrying 0xB3 → next edge EMPTY, `valid_o`=0, `data_o`=BUBBLE, `ready_o`=1; 0xB3 never appears on the output.
- CNT_W=4, hold a stall for 20 edges → `stall_cnt_o` saturates at 15. Then `stall_clr_i`=1 → 0. With `stall_clr_i` and a stall in the same cycle, the clear wins.
